reg_hazard_scoreboard: RTL and testbench

- Scoreboard controller that sequences access to the 31-entry pipelined register file.
- Tracks outstanding writes per register and stalls issue on RAW/overflow hazards.
- Schedules the interrupt/exception link write (PC+4 into $26 or $31) on the file's write port only after all older writes to that register have retired.
- Sits between decode/issue and the register file; drives the file's link-write enable and address.

---
 rtl/reg_hazard_scoreboard_pkg.sv | 15 +
 rtl/reg_hazard_scoreboard_pend_counter.sv | 36 +++
 rtl/reg_hazard_scoreboard.sv | 97 +++++++++
 tb/tb_reg_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_hazard_scoreboard_pkg.sv
// Shared types and constants for the register hazard scoreboard.
package reg_hazard_scoreboard_pkg;

  localparam int unsigned CNT_W_DEF    = 2;
  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam logic [4:0]  LINK_EXC_DEF = 5'd26;
  localparam logic [4:0]  LINK_IRQ_DEF = 5'd31;

  typedef enum logic [1:0] {
    LINK_IDLE,
    LINK_WAIT,
    LINK_GRANT
  } link_state_e;

endpackage

// File: rtl/reg_hazard_scoreboard_pend_counter.sv
// Per-register outstanding-write counter; saturates at both ends.
module reg_pend_counter
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nonzero,
  output logic full,
  output logic underflow
);

  logic [CNT_W-1:0] cnt;

  assign nonzero = |cnt;
  assign full    = &cnt;
  // Simultaneous inc/dec nets to zero change, so it can never underflow.
  assign underflow = dec & ~inc & ~clr & ~nonzero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc & ~dec & ~full) begin
      cnt <= cnt + 1'b1;
    end else if (dec & ~inc & nonzero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// Issue scoreboard for the 31-entry register file plus the link-write
// sequencer that waits for older writes to the link register to retire.
module reg_hazard_scoreboard
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter logic [4:0]  LINK_EXC = LINK_EXC_DEF,
  parameter logic [4:0]  LINK_IRQ = LINK_IRQ_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic [4:0]  issue_rd,
  input  logic        issue_wr,
  output logic        issue_ready,
  input  logic        retire_valid,
  input  logic [4:0]  retire_rd,
  input  logic        flush,
  input  logic        link_req,
  input  logic        link_is_exc,
  input  logic        kernel_mode,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic        link_busy,
  output logic [31:0] pending_mask,
  output logic        err_underflow
);

  link_state_e state;
  logic [31:0] nz;
  logic [31:0] full;
  logic [31:0] uf;
  logic        hazard;
  logic        accept;

  // Register 0 is never tracked, so its status bits are tied low.
  assign nz[0]   = 1'b0;
  assign full[0] = 1'b0;
  assign uf[0]   = 1'b0;

  for (genvar i = 1; i < 32; i++) begin : g_cnt
    reg_pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (accept & issue_wr & (issue_rd == 5'(i))),
      .dec       (retire_valid & (retire_rd == 5'(i))),
      .clr       (flush),
      .nonzero   (nz[i]),
      .full      (full[i]),
      .underflow (uf[i])
    );
  end

  assign hazard       = nz[issue_rs] | nz[issue_rt] | (issue_wr & full[issue_rd]);
  assign issue_ready  = ~hazard & (state == LINK_IDLE);
  assign accept       = issue_valid & issue_ready;
  assign pending_mask = nz;
  assign link_busy    = (state != LINK_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_underflow <= 1'b0;
    end else if (|uf) begin
      err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LINK_IDLE;
      link_we   <= 1'b0;
      link_addr <= REG_ZERO;
    end else begin
      case (state)
        LINK_IDLE: begin
          if (link_req & ~kernel_mode) begin
            link_addr <= link_is_exc ? LINK_EXC : LINK_IRQ;
            state     <= LINK_WAIT;
          end
        end
        LINK_WAIT: begin
          if (!nz[link_addr]) begin
            state   <= LINK_GRANT;
            link_we <= 1'b1;
          end
        end
        default: begin
          state   <= LINK_IDLE;
          link_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a
// counter-array reference model of the scoreboard rules.
module tb_reg_hazard_scoreboard;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_wr, retire_valid, flush;
  logic [4:0]  issue_rs, issue_rt, issue_rd, retire_rd;
  logic        link_req, link_is_exc, kernel_mode;
  logic        issue_ready, link_we, link_busy, err_underflow;
  logic [4:0]  link_addr;
  logic [31:0] pending_mask;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding-write count per register and link progress.
  int         mcnt [32];
  bit         merr;
  int         mphase;   // 0 idle, 1 waiting for link reg to drain, 2 writing
  logic [4:0] maddr;

  always #5 clk = ~clk;

  reg_hazard_scoreboard #(.CNT_W(2), .LINK_EXC(5'd26), .LINK_IRQ(5'd31)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_ready(issue_ready),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .flush(flush),
    .link_req(link_req), .link_is_exc(link_is_exc), .kernel_mode(kernel_mode),
    .link_we(link_we), .link_addr(link_addr), .link_busy(link_busy),
    .pending_mask(pending_mask), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    merr   = 1'b0;
    mphase = 0;
    maddr  = 5'd0;
  endtask

  task automatic step(input bit iv, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input bit wr, input bit rv,
                      input logic [4:0] rrd, input bit fl, input bit lr,
                      input bit exc, input bit km);
    bit haz, rdy;
    logic [31:0] emask;
    issue_valid = iv; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_wr = wr;
    retire_valid = rv; retire_rd = rrd; flush = fl;
    link_req = lr; link_is_exc = exc; kernel_mode = km;
    #1;
    haz = (rs != 0 && mcnt[rs] > 0) || (rt != 0 && mcnt[rt] > 0) ||
          (wr && rd != 0 && mcnt[rd] == MAXC);
    rdy = !haz && mphase == 0;
    emask = '0;
    for (int i = 1; i < 32; i++) if (mcnt[i] > 0) emask[i] = 1'b1;
    chk("issue_ready",  32'(issue_ready),   32'(rdy));
    chk("pending_mask", pending_mask,       emask);
    chk("link_we",      32'(link_we),       32'(mphase == 2));
    chk("link_busy",    32'(link_busy),     32'(mphase != 0));
    chk("link_addr",    32'(link_addr),     32'(maddr));
    chk("err_underflow",32'(err_underflow), 32'(merr));
    @(posedge clk);
    case (mphase)
      0: if (lr && !km) begin maddr = exc ? 5'd26 : 5'd31; mphase = 1; end
      1: if (mcnt[maddr] == 0) mphase = 2;
      default: mphase = 0;
    endcase
    if (fl) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      if (iv && rdy && wr && rd != 0) mcnt[rd]++;
      if (rv && rrd != 0) begin
        if (mcnt[rrd] == 0) merr = 1'b1;
        else mcnt[rrd]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_flush();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 11) return 5'(r);
    if (r == 12) return 5'd26;
    if (r == 13) return 5'd31;
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    reset = 1'b0;
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0; issue_wr = 0;
    retire_valid = 0; retire_rd = 0; flush = 0;
    link_req = 0; link_is_exc = 0; kernel_mode = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mask", pending_mask, 32'h0);
    chk("rst_we",   32'(link_we), 32'h0);
    chk("rst_addr", 32'(link_addr), 32'h0);
    chk("rst_busy", 32'(link_busy), 32'h0);
    chk("rst_err",  32'(err_underflow), 32'h0);
    reset = 1'b1;

    // Basic RAW stall and release
    step(1, 3, 4, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("tp1_mask", pending_mask, 32'h20);
    step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Per-register overflow stall
    repeat (3) step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    do_flush();

    // Same-cycle issue/retire, then genuine underflow
    step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 9, 1, 1, 9, 0, 0, 0, 0);
    chk("simul_err", 32'(err_underflow), 32'h0);
    step(0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0);
    chk("uf_set", 32'(err_underflow), 32'h1);
    idle();
    chk("uf_sticky", 32'(err_underflow), 32'h1);
    do_flush();

    // Exception link waits for two writes to $26
    step(1, 0, 0, 26, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 26, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle();
    idle();
    step(0, 0, 0, 0, 0, 1, 26, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 26, 0, 0, 0, 0);
    idle();
    chk("exc_we", 32'(link_we), 32'h1);
    chk("exc_addr", 32'(link_addr), 32'd26);
    idle();
    chk("exc_idle", 32'(link_busy), 32'h0);

    // Kernel-mode request dropped, user-mode request granted in 2 cycles
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("km_drop", 32'(link_busy), 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    chk("irq_we", 32'(link_we), 32'h1);
    chk("irq_addr", 32'(link_addr), 32'd31);
    idle();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bit iv, wr, rv, fl, lr, exc, km;
      logic [4:0] rrd;
      iv  = ($urandom_range(0, 9) < 7);
      wr  = ($urandom_range(0, 9) < 6);
      rrd = pick_reg();
      rv  = ($urandom_range(0, 1) == 1);
      if (rv && mcnt[rrd] == 0 && $urandom_range(0, 49) != 0) rv = 1'b0;
      fl  = ($urandom_range(0, 99) == 0);
      lr  = ($urandom_range(0, 29) == 0);
      exc = ($urandom_range(0, 1) == 1);
      km  = ($urandom_range(0, 3) == 0);
      step(iv, pick_reg(), pick_reg(), pick_reg(), wr, rv, rrd, fl, lr, exc, km);
    end
    do_flush();
    idle();

    // Flush during WAIT, then reset during GRANT
    step(1, 0, 0, 31, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 31, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    chk("fl_wait", 32'(link_busy), 32'h1);
    do_flush();
    chk("fl_mask", pending_mask, 32'h0);
    idle();
    chk("fl_grant", 32'(link_we), 32'h1);
    reset = 1'b0;
    #1;
    chk("arst_we", 32'(link_we), 32'h0);
    chk("arst_busy", 32'(link_busy), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
